// File: rtl/pc_fetch_seq.sv
// Fetch controller for the single-issue CPU.
// Owns the program counter, fetches one instruction at a time over an imem
// req/ack handshake, holds it for decode, and applies the decode-stage branch
// decision (pc+4 or pc+4+sext(imm16)) when the instruction is consumed.
module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  input  logic        br_taken,
  input  logic [15:0] br_imm16,
  input  logic        halt,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT,
    S_ERR
  } state_t;

  // Last no-ack cycle allowed before the fetch is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;
  logic [31:0] br_offset;
  logic        consume;

  assign consume   = (state == S_ISSUE) && dec_ready;
  assign br_offset = br_taken ? {{16{br_imm16[15]}}, br_imm16} : 32'h0;
  assign imem_addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no
    // latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:  state_next = halt ? S_HALT : S_FETCH;
      S_FETCH: begin
        // An ack in the final wait cycle takes priority over the timeout.
        if (imem_ack)                   state_next = S_ISSUE;
        else if (wait_cnt == WAIT_LAST) state_next = S_ERR;
      end
      S_ISSUE: begin
        if (dec_ready) state_next = halt ? S_HALT : S_FETCH;
      end
      default: state_next = state;  // HALT and ERR leave only via reset
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    imem_req   = (state == S_FETCH);
    inst_valid = (state == S_ISSUE);
    halted     = (state == S_HALT);
    err        = (state == S_ERR);
  end

  // PC, wait counter, instruction hold registers and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      wait_cnt <= 8'd0;
      inst     <= 32'h0;
      inst_pc  <= 32'h0;
      retired  <= 16'd0;
    end else begin
      if (state == S_FETCH) begin
        if (imem_ack) begin
          inst     <= imem_data;
          inst_pc  <= pc;
          wait_cnt <= 8'd0;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
      // Branch offset is a byte offset added unshifted; all math wraps mod 2^32.
      if (consume) begin
        pc      <= pc + 32'd4 + br_offset;
        retired <= retired + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: sequential fetch, branches, backpressure,
// ack-before-timeout, halt, mid-operation reset, timeout and halt-in-IDLE.
// A second instance with RESET_PC=FFFF_FFFC shares the inputs to show PC wrap.
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        dec_ready;
  logic        br_taken;
  logic [15:0] br_imm16;
  logic        halt;

  logic        imem_req, inst_valid, halted, err;
  logic [31:0] imem_addr, inst, inst_pc;
  logic [15:0] retired;

  logic        w_imem_req, w_inst_valid, w_halted, w_err;
  logic [31:0] w_imem_addr, w_inst, w_inst_pc;
  logic [15:0] w_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_seq #(.RESET_PC(32'h0000_0000), .MAX_WAIT(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .dec_ready(dec_ready), .br_taken(br_taken), .br_imm16(br_imm16),
    .halt(halt), .halted(halted), .err(err), .retired(retired)
  );

  pc_fetch_seq #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(3)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
    .dec_ready(dec_ready), .br_taken(br_taken), .br_imm16(br_imm16),
    .halt(halt), .halted(w_halted), .err(w_err), .retired(w_retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one fetch: wait for req, check address, stall dly cycles, then ack.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                          input int dly, input string tag);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    for (int i = 0; i < dly; i++) begin
      step();
      check({tag, "_wait_req"}, {31'b0, imem_req}, 32'd1);
      check({tag, "_wait_addr"}, imem_addr, exp_addr);
    end
    imem_ack  = 1'b1;
    imem_data = data;
    step();
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, "_inst"}, inst, data);
    check({tag, "_inst_pc"}, inst_pc, exp_addr);
    check({tag, "_req_drop"}, {31'b0, imem_req}, 32'd0);
  endtask

  // Consume the held instruction with the given branch decision and halt.
  task automatic consume(input logic br, input logic [15:0] imm, input logic hlt);
    dec_ready = 1'b1;
    br_taken  = br;
    br_imm16  = imm;
    halt      = hlt;
    step();
    dec_ready = 1'b0;
    br_taken  = 1'b0;
    br_imm16  = 16'h0;
    halt      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    dec_ready = 1'b0; br_taken = 1'b0; br_imm16 = 16'h0; halt = 1'b0;
    step();
    step();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_retired", {16'b0, retired}, 32'd0);
    check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);

    // IDLE for one cycle, then FETCH.
    rst_n = 1'b1;
    step();

    // Sequential fetch 0x0..0xC.
    for (int i = 0; i < 4; i++) begin
      do_fetch(32'(i * 4), 32'hA000_0000 + 32'(i), 0, "seq");
      if (i == 0) check("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
      consume(1'b0, 16'h0, 1'b0);
      check("seq_retired", {16'b0, retired}, 32'(i + 1));
      if (i == 0) check("wrap_next_addr", w_imem_addr, 32'h0);
    end

    // 0x10 -> taken +0xEC -> 0x100; 0x100 -> +0x10 -> 0x114; 0x114 -> -0x10 -> 0x108.
    do_fetch(32'h10, 32'hB000_0010, 0, "br0");
    consume(1'b1, 16'h00EC, 1'b0);
    do_fetch(32'h100, 32'hB000_0100, 0, "br_pos");
    consume(1'b1, 16'h0010, 1'b0);
    do_fetch(32'h114, 32'hB000_0114, 0, "br_neg");
    consume(1'b1, 16'hFFF0, 1'b0);

    // Backpressure at 0x108 with a stray branch pulse.
    do_fetch(32'h108, 32'hC0DE_0108, 0, "bp");
    for (int i = 0; i < 5; i++) begin
      br_taken = (i == 2);
      br_imm16 = 16'h0400;
      step();
      check("bp_valid", {31'b0, inst_valid}, 32'd1);
      check("bp_inst", inst, 32'hC0DE_0108);
      check("bp_inst_pc", inst_pc, 32'h108);
      check("bp_req", {31'b0, imem_req}, 32'd0);
      check("bp_retired", {16'b0, retired}, 32'd7);
    end
    br_taken = 1'b0;
    br_imm16 = 16'h0;
    consume(1'b0, 16'h0, 1'b0);
    check("bp_next_addr", imem_addr, 32'h10C);
    check("bp_next_req", {31'b0, imem_req}, 32'd1);
    check("bp_retired_after", {16'b0, retired}, 32'd8);

    // Reset while a fetch is being acked: ack ignored, everything cleared.
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF; rst_n = 1'b0;
    step();
    imem_ack = 1'b0; imem_data = 32'h0;
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    check("mid_rst_inst", inst, 32'h0);
    check("mid_rst_inst_pc", inst_pc, 32'h0);
    check("mid_rst_retired", {16'b0, retired}, 32'd0);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Ack on the 3rd wait cycle wins over the timeout.
    do_fetch(32'h0, 32'h1234_5678, 2, "late_ack");
    check("late_ack_err", {31'b0, err}, 32'd0);
    consume(1'b0, 16'h0, 1'b0);

    // Halt raised during FETCH: fetch completes, instruction consumed, then HALT.
    halt = 1'b1;
    do_fetch(32'h4, 32'h8765_4321, 1, "halt_fetch");
    consume(1'b0, 16'h0, 1'b1);
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_valid", {31'b0, inst_valid}, 32'd0);
    check("halt_retired", {16'b0, retired}, 32'd2);
    check("halt_wrap_halted", {31'b0, w_halted}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_no_req", {31'b0, imem_req}, 32'd0);
      check("halt_stays", {31'b0, halted}, 32'd1);
    end

    // Timeout: three FETCH cycles without ack.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("to_pre_err", {31'b0, err}, 32'd0);
    check("to_pre_req", {31'b0, imem_req}, 32'd1);
    step();
    check("to_err", {31'b0, err}, 32'd1);
    check("to_req", {31'b0, imem_req}, 32'd0);
    check("to_wrap_err", {31'b0, w_err}, 32'd1);
    imem_ack = 1'b1;
    step();
    step();
    imem_ack = 1'b0;
    check("to_sticky", {31'b0, err}, 32'd1);
    check("to_addr_frozen", imem_addr, 32'h0);
    check("to_valid", {31'b0, inst_valid}, 32'd0);

    // Halt during IDLE goes straight to HALT with nothing retired.
    rst_n = 1'b0; halt = 1'b1;
    step();
    check("idle_rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    step();
    halt = 1'b0;
    check("idle_halted", {31'b0, halted}, 32'd1);
    check("idle_req", {31'b0, imem_req}, 32'd0);
    check("idle_retired", {16'b0, retired}, 32'd0);
    check("idle_wrap_req", {31'b0, w_imem_req}, 32'd0);
    check("idle_wrap_valid", {31'b0, w_inst_valid}, 32'd0);
    check("idle_wrap_inst", w_inst, 32'h0);
    check("idle_wrap_retired", {16'b0, w_retired}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Sequential fetch controller that owns the program counter and drives the existing PC-increment/branch datapath.
- Issues instruction-memory requests with a req/ack handshake and holds each fetched instruction until decode accepts it.
- Applies the decode-stage branch decision (PC+4 or PC+4+sign-extended imm16) to form the next PC.
- Sits between instruction memory and the decode stage of the single-issue CE361 CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, fetch cycles without imem_ack before entering ERR (range 1..255).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address; equals pc while imem_req=1
- imem_ack  in  1  memory has returned data this cycle
- imem_data  in  32  instruction word, valid when imem_ack=1
- inst_valid  out  1  inst/inst_pc hold a fetched, unconsumed instruction
- inst  out  32  fetched instruction
- inst_pc  out  32  address of inst
- dec_ready  in  1  decode accepts inst this cycle
- br_taken  in  1  branch select (nPC_sel) for the instruction being consumed
- br_imm16  in  16  branch offset for the instruction being consumed
- halt  in  1  stop request
- halted  out  1  controller is in HALT
- err  out  1  fetch timeout occurred (sticky)
- retired  out  16  count of consumed instructions, wraps at 2^16

Behaviour:
- Reset (rst_n=0 at an edge), including mid-operation:
  - Internal pc=RESET_PC, state=IDLE, wait counter=0.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0, err=0, retired=0.
  - An imem_ack in the reset cycle is ignored.
- States and transitions (registered outputs):
  - IDLE: one cycle after reset. halt=1 → HALT, else → FETCH.
  - FETCH: imem_req=1, imem_addr=pc held stable until ack.
    - Each cycle without imem_ack increments the wait counter.
    - If the counter reaches MAX_WAIT with no ack → ERR.
    - On imem_ack: inst←imem_data, inst_pc←pc, inst_valid←1, wait counter←0, → ISSUE. imem_req drops on the same edge.
    - An ack arriving in the same cycle the counter would hit MAX_WAIT wins; no ERR.
    - halt is not acted on in FETCH; an outstanding fetch is never abandoned.
  - ISSUE: inst_valid=1; inst, inst_pc, pc held until dec_ready=1.
    - Consume edge (inst_valid & dec_ready):
      - pc ← br_taken ? pc+4+sext(br_imm16) : pc+4.
      - sext replicates bit 15 into bits 31:16.
      - Offset is a byte offset added unshifted, matching the existing branch datapath.
      - inst_valid←0, retired←retired+1.
      - Then → HALT if halt=1 that cycle, else → FETCH.
    - br_taken/br_imm16 are ignored on all non-consume cycles.
  - HALT: halted=1, imem_req=0, inst_valid=0. Exits only via reset.
  - ERR: err=1, imem_req=0, inst_valid=0, pc frozen. Exits only via reset.
- Arithmetic:
  - All PC math is modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0.
  - Negative offsets wrap the same way.
- Latency and throughput:
  - Minimum 1 cycle from req to ack; an instruction becomes visible the cycle after ack.
  - Peak rate is one instruction every 2 cycles (FETCH, ISSUE).
- imem_ack outside FETCH is ignored. imem_data is don't-care when imem_ack=0.
- Only one request is ever outstanding.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: RESET_PC=0; memory acks 1 cycle after each req; dec_ready=1; br_taken=0.
  - Response: imem_addr sequence 0x0, 0x4, 0x8, 0xC; inst_pc matches; retired=4 after the 4th consume; req/ack never overlap across fetches.
- Taken branch, positive and negative:
  - At inst_pc=0x100, br_taken=1, br_imm16=16'h0010 → next imem_addr=0x114.
  - At inst_pc=0x114, br_taken=1, br_imm16=16'hFFF0 → next imem_addr=0x108.
- Backpressure:
  - Stimulus: hold dec_ready=0 for 5 cycles in ISSUE.
  - Response: inst/inst_pc/inst_valid stable, no new imem_req, retired unchanged. br_taken=1 pulsed during the stall has no effect.
- Timeout:
  - MAX_WAIT=3 with no ack → err=1 after 3 FETCH cycles; imem_req=0; stays until rst_n=0.
  - Ack on the 3rd wait cycle → no err; instruction delivered.
- Halt:
  - halt asserted in FETCH → fetch completes; instruction is consumed; then halted=1 and no further req.
  - halt=1 during IDLE → HALT directly with retired=0.
- Wrap and mid-op reset:
  - RESET_PC=32'hFFFF_FFFC, sequential consume → next imem_addr=0x0.
  - rst_n=0 while imem_req=1 and imem_ack=1 → next cycle all outputs at reset values; inst_valid=0.
